// File: rtl/collision_arbiter_if.sv
// Bus between the drawing-request muxes and the collision arbiter.
// master = request side (mux/testbench), slave = collision_arbiter.
interface collision_arbiter_if #(
    parameter int NUM_TARGETS        = 8,
    parameter int MAX_HITS_PER_FRAME = 1
);
    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int CNT_W = $clog2(MAX_HITS_PER_FRAME + 1);

    logic                   startOfFrame;
    logic                   enable;
    logic                   drawing_request_Player;
    logic [NUM_TARGETS-1:0] drawing_request_Targets;
    logic [NUM_TARGETS-1:0] target_mask;

    logic                   any_collision;
    logic [NUM_TARGETS-1:0] hit_pulse;
    logic                   hit_valid;
    logic [IDX_W-1:0]       hit_index;
    logic [CNT_W-1:0]       hits_this_frame;
    logic                   frame_locked;
    logic [NUM_TARGETS-1:0] cooldown_active;
    logic [15:0]            total_hits;

    modport master (
        output startOfFrame, enable, drawing_request_Player,
               drawing_request_Targets, target_mask,
        input  any_collision, hit_pulse, hit_valid, hit_index,
               hits_this_frame, frame_locked, cooldown_active, total_hits
    );

    modport slave (
        input  startOfFrame, enable, drawing_request_Player,
               drawing_request_Targets, target_mask,
        output any_collision, hit_pulse, hit_valid, hit_index,
               hits_this_frame, frame_locked, cooldown_active, total_hits
    );
endinterface

// File: rtl/collision_arbiter.sv
// Player-vs-targets collision arbiter: per-frame hit budget, per-target
// multi-frame cooldown, one-cycle one-hot hit pulses plus binary index.
// Optional hit statistics counter: define COLLISION_ARBITER_STATS_EN.
module collision_arbiter #(
    parameter int NUM_TARGETS        = 8,
    parameter int MAX_HITS_PER_FRAME = 1,
    parameter int COOLDOWN_FRAMES    = 2,
    parameter int CD_W               = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    collision_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int CNT_W = $clog2(MAX_HITS_PER_FRAME + 1);

    typedef enum logic { ARMED = 1'b0, LOCKED = 1'b1 } state_t;

    state_t                             state_q, state_d;
    logic [NUM_TARGETS-1:0][CD_W-1:0]   cd_q, cd_eff, cd_nxt;
    logic [NUM_TARGETS-1:0]             htf_q, htf_eff;
    logic [NUM_TARGETS-1:0]             elig, win_oh;
    logic [CNT_W-1:0]                   cnt_q, cnt_eff, cnt_inc;
    logic [IDX_W-1:0]                   win_idx;
    logic                               sof, armed_eff, accept;
    logic [NUM_TARGETS-1:0]             hit_pulse_q;
    logic                               hit_valid_q;
    logic [IDX_W-1:0]                   hit_index_q;

    // Frame-start view: apply the frame clear first so an overlap on the
    // startOfFrame cycle is judged as the first event of the new frame.
    always_comb begin
        sof       = bus.startOfFrame;
        htf_eff   = sof ? '0 : htf_q;
        cnt_eff   = sof ? '0 : cnt_q;
        armed_eff = sof || (state_q == ARMED);
        for (int i = 0; i < NUM_TARGETS; i++) begin
            cd_eff[i] = (sof && cd_q[i] != '0) ? cd_q[i] - 1'b1 : cd_q[i];
            elig[i]   = bus.drawing_request_Player & bus.drawing_request_Targets[i]
                      & bus.target_mask[i] & (cd_eff[i] == '0) & ~htf_eff[i];
        end
    end

    // Lowest eligible index wins; descending scan leaves the lowest last.
    always_comb begin
        win_idx = '0;
        win_oh  = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx    = IDX_W'(i);
                win_oh     = '0;
                win_oh[i]  = 1'b1;
            end
        end
        accept  = bus.enable && armed_eff && (elig != '0);
        cnt_inc = cnt_eff + CNT_W'(1);
        for (int i = 0; i < NUM_TARGETS; i++)
            cd_nxt[i] = (accept && win_oh[i]) ? CD_W'(COOLDOWN_FRAMES) : cd_eff[i];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (resetN) state_q <= ARMED;
        else        state_q <= state_d;
    end

    // FSM next state: lock on the hit that exhausts the budget, re-arm on frame start.
    always_comb begin
        state_d = state_q;
        if (accept && cnt_inc == CNT_W'(MAX_HITS_PER_FRAME)) state_d = LOCKED;
        else if (sof)                                        state_d = ARMED;
    end

    // FSM outputs.
    always_comb begin
        bus.frame_locked = (state_q == LOCKED);
    end

    // Per-frame bookkeeping and registered hit outputs.
    always_ff @(posedge clk) begin
        if (resetN) begin
            cd_q        <= '0;
            htf_q       <= '0;
            cnt_q       <= '0;
            hit_pulse_q <= '0;
            hit_valid_q <= 1'b0;
            hit_index_q <= '0;
        end else begin
            cd_q        <= cd_nxt;
            htf_q       <= htf_eff | (accept ? win_oh : '0);
            cnt_q       <= accept ? cnt_inc : cnt_eff;
            hit_pulse_q <= accept ? win_oh : '0;
            hit_valid_q <= accept;
            if (accept) hit_index_q <= win_idx;
        end
    end

    // Collision indication is raw overlap, independent of enable/lock/cooldown.
    always_comb begin
        bus.any_collision = bus.drawing_request_Player
                          & |(bus.drawing_request_Targets & bus.target_mask);
        for (int i = 0; i < NUM_TARGETS; i++)
            bus.cooldown_active[i] = (cd_q[i] != '0);
    end

    assign bus.hit_pulse       = hit_pulse_q;
    assign bus.hit_valid       = hit_valid_q;
    assign bus.hit_index       = hit_index_q;
    assign bus.hits_this_frame = cnt_q;

`ifdef COLLISION_ARBITER_STATS_EN
    logic [15:0] total_q;

    // Lifetime hit count, saturating; only reset clears it.
    always_ff @(posedge clk) begin
        if (resetN)                          total_q <= '0;
        else if (accept && total_q != 16'hFFFF) total_q <= total_q + 16'd1;
    end

    assign bus.total_hits = total_q;
`else
    assign bus.total_hits = 16'h0000;
`endif
endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboarded bench for collision_arbiter: two instances (MAX=1/CD=2 and
// MAX=2/CD=0); stimulus pushes expected hits, a negedge monitor pops them.
module tb_collision_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct { int cyc; int idx; int cnt; int locked; } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    collision_arbiter_if #(.NUM_TARGETS(8), .MAX_HITS_PER_FRAME(1)) ia ();
    collision_arbiter_if #(.NUM_TARGETS(8), .MAX_HITS_PER_FRAME(2)) ib ();

    collision_arbiter #(.NUM_TARGETS(8), .MAX_HITS_PER_FRAME(1),
                        .COOLDOWN_FRAMES(2), .CD_W(4))
        u_a (.clk(clk), .resetN(rst), .bus(ia));

    collision_arbiter #(.NUM_TARGETS(8), .MAX_HITS_PER_FRAME(2),
                        .COOLDOWN_FRAMES(0), .CD_W(4))
        u_b (.clk(clk), .resetN(rst), .bus(ib));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Monitor: every hit_valid must match the oldest expected hit.
    always @(negedge clk) begin
        exp_t e;
        if (ia.hit_valid === 1'b1) begin
            if (qa.size() == 0) chk("A_unexpected_hit", 32'(ia.hit_index), 32'hDEAD);
            else begin
                e = qa.pop_front();
                chk("A_hit_cycle",  32'(cyc),                e.cyc);
                chk("A_hit_pulse",  32'(ia.hit_pulse),       32'(1) << e.idx);
                chk("A_hit_index",  32'(ia.hit_index),       e.idx);
                chk("A_hit_count",  32'(ia.hits_this_frame), e.cnt);
                chk("A_hit_locked", 32'(ia.frame_locked),    e.locked);
            end
        end else if (ia.hit_pulse !== 8'h00 && !rst) chk("A_idle_pulse", 32'(ia.hit_pulse), 0);
        if (ib.hit_valid === 1'b1) begin
            if (qb.size() == 0) chk("B_unexpected_hit", 32'(ib.hit_index), 32'hDEAD);
            else begin
                e = qb.pop_front();
                chk("B_hit_cycle",  32'(cyc),                e.cyc);
                chk("B_hit_pulse",  32'(ib.hit_pulse),       32'(1) << e.idx);
                chk("B_hit_index",  32'(ib.hit_index),       e.idx);
                chk("B_hit_count",  32'(ib.hits_this_frame), e.cnt);
                chk("B_hit_locked", 32'(ib.frame_locked),    e.locked);
            end
        end else if (ib.hit_pulse !== 8'h00 && !rst) chk("B_idle_pulse", 32'(ib.hit_pulse), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        ia.startOfFrame = 0; ia.enable = 1; ia.drawing_request_Player = 0;
        ia.drawing_request_Targets = 8'h00; ia.target_mask = 8'hFF;
        ib.startOfFrame = 0; ib.enable = 1; ib.drawing_request_Player = 0;
        ib.drawing_request_Targets = 8'h00; ib.target_mask = 8'hFF;

        // Reset state
        tick; look;
        chk("rst_hit_valid", 32'(ia.hit_valid), 0);
        chk("rst_hit_pulse", 32'(ia.hit_pulse), 0);
        chk("rst_hit_index", 32'(ia.hit_index), 0);
        chk("rst_hits",      32'(ia.hits_this_frame), 0);
        chk("rst_locked",    32'(ia.frame_locked), 0);
        chk("rst_cooldown",  32'(ia.cooldown_active), 0);
        chk("rst_total",     32'(ia.total_hits), 0);
        tick; rst = 0;

        // A: target 3 overlaps 5 cycles -> exactly one hit, frame locks
        ia.drawing_request_Player = 1; ia.drawing_request_Targets = 8'h08;
        qa.push_back('{cyc + 1, 3, 1, 1});
        look; chk("A_anycol_t3", 32'(ia.any_collision), 1);
        repeat (5) tick;
        look;
        chk("A_t1_locked",   32'(ia.frame_locked), 1);
        chk("A_t1_hits",     32'(ia.hits_this_frame), 1);
        chk("A_t1_cooldown", 32'(ia.cooldown_active), 32'h08);
        ia.drawing_request_Player = 0; ia.drawing_request_Targets = 8'h00;

        // A: cooldown of 2 frames on target 0 under continuous overlap
        ia.startOfFrame = 1; tick; ia.startOfFrame = 0;
        ia.drawing_request_Player = 1; ia.drawing_request_Targets = 8'h01;
        qa.push_back('{cyc + 1, 0, 1, 1});
        repeat (3) tick;
        ia.startOfFrame = 1; tick; ia.startOfFrame = 0;
        repeat (2) tick; look;
        chk("A_cd_frameN1_active", 32'(ia.cooldown_active), 32'h01);
        chk("A_cd_frameN1_unlocked", 32'(ia.frame_locked), 0);
        ia.startOfFrame = 1;
        qa.push_back('{cyc + 1, 0, 1, 1});
        tick; ia.startOfFrame = 0;
        tick; look;
        chk("A_cd_frameN2_locked", 32'(ia.frame_locked), 1);

        // A: startOfFrame with overlap on target 1 while locked
        ia.drawing_request_Targets = 8'h02; ia.startOfFrame = 1;
        qa.push_back('{cyc + 1, 1, 1, 1});
        tick; ia.startOfFrame = 0;
        tick; look;
        chk("A_sof_hits", 32'(ia.hits_this_frame), 1);
        ia.drawing_request_Player = 0; ia.drawing_request_Targets = 8'h00;

        // A: masked target 4 ignored, target 6 wins
        ia.startOfFrame = 1; tick; ia.startOfFrame = 0;
        ia.target_mask = 8'hEF; ia.drawing_request_Targets = 8'h50;
        ia.drawing_request_Player = 1;
        qa.push_back('{cyc + 1, 6, 1, 1});
        look; chk("A_mask_anycol", 32'(ia.any_collision), 1);
        tick;
        ia.drawing_request_Targets = 8'h10;
        look; chk("A_mask_only4_anycol", 32'(ia.any_collision), 0);

        // A: enable=0 -> no hits, any_collision still reported
        ia.enable = 0; ia.drawing_request_Targets = 8'h50; ia.startOfFrame = 1;
        tick; ia.startOfFrame = 0;
        repeat (3) tick; look;
        chk("A_dis_anycol", 32'(ia.any_collision), 1);
        chk("A_dis_locked", 32'(ia.frame_locked), 0);
        chk("A_dis_hits",   32'(ia.hits_this_frame), 0);
        chk("A_dis_cooldown", 32'(ia.cooldown_active), 32'h40);
        ia.enable = 1; ia.drawing_request_Player = 0;
        ia.drawing_request_Targets = 8'h00; ia.target_mask = 8'hFF;
        tick; look;
`ifdef COLLISION_ARBITER_STATS_EN
        chk("A_total_hits", 32'(ia.total_hits), 5);
`else
        chk("A_total_hits_off", 32'(ia.total_hits), 0);
`endif

        // B: targets 2 and 5 together -> 2 then 5, frame locks at 2 hits
        ib.startOfFrame = 1; tick; ib.startOfFrame = 0;
        ib.drawing_request_Player = 1; ib.drawing_request_Targets = 8'h24;
        qb.push_back('{cyc + 1, 2, 1, 0});
        qb.push_back('{cyc + 2, 5, 2, 1});
        repeat (3) tick; look;
        chk("B_hits2",    32'(ib.hits_this_frame), 2);
        chk("B_locked",   32'(ib.frame_locked), 1);
        chk("B_cooldown", 32'(ib.cooldown_active), 0);

        // B: zero cooldown, hit on startOfFrame still blocked rest of frame
        ib.drawing_request_Targets = 8'h04; ib.startOfFrame = 1;
        qb.push_back('{cyc + 1, 2, 1, 0});
        tick; ib.startOfFrame = 0;
        repeat (2) tick; look;
        chk("B_blocked_hits", 32'(ib.hits_this_frame), 1);

        // Mid-frame reset wins over a pending overlap on A
        ia.drawing_request_Player = 1; ia.drawing_request_Targets = 8'h80;
        rst = 1; tick; look;
        chk("mrst_A_valid",    32'(ia.hit_valid), 0);
        chk("mrst_A_index",    32'(ia.hit_index), 0);
        chk("mrst_A_cooldown", 32'(ia.cooldown_active), 0);
        chk("mrst_A_total",    32'(ia.total_hits), 0);
        chk("mrst_B_hits",     32'(ib.hits_this_frame), 0);
        chk("mrst_B_locked",   32'(ib.frame_locked), 0);
        chk("mrst_B_index",    32'(ib.hit_index), 0);
        rst = 0;
        qa.push_back('{cyc + 1, 7, 1, 1});
        qb.push_back('{cyc + 1, 2, 1, 0});
        tick;
        ia.drawing_request_Player = 0; ia.drawing_request_Targets = 8'h00;
        ib.drawing_request_Player = 0; ib.drawing_request_Targets = 8'h00;
        repeat (3) tick; look;
`ifdef COLLISION_ARBITER_STATS_EN
        chk("A_total_after_rst", 32'(ia.total_hits), 1);
`endif
        chk("A_queue_drained", 32'(qa.size()), 0);
        chk("B_queue_drained", 32'(qb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/collision_arbiter.md
Name: collision_arbiter

Overview:
- Parametrised successor to the single-flag collision logic.
- Arbitrates overlaps between the player sprite and NUM_TARGETS target sprites within each video frame.
- Allows up to MAX_HITS_PER_FRAME distinct hits per frame, with per-target multi-frame cooldown.
- Sits between the drawing-request muxes and the score/object managers; emits one-cycle, one-hot hit pulses plus a binary index.

Parameters:
- NUM_TARGETS, 8: number of target drawing-request channels (1..32).
- MAX_HITS_PER_FRAME, 1: distinct target hits accepted per frame before lock (1..NUM_TARGETS).
- COOLDOWN_FRAMES, 2: frames a target stays ineligible after a hit (0 = no cooldown beyond the current frame).
- CD_W, 4: cooldown counter width; COOLDOWN_FRAMES must be less than 2^CD_W.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous reset, active-high (asserted = 1, sampled on posedge clk only).
- startOfFrame  in  1  single-cycle pulse at frame start.
- enable  in  1  0 = no new hits accepted; frame/cooldown bookkeeping continues.
- drawing_request_Player  in  1  player pixel active.
- drawing_request_Targets  in  NUM_TARGETS  per-target pixel active.
- target_mask  in  NUM_TARGETS  1 = target currently alive/eligible.
- any_collision  out  1  combinational: player AND any (target AND mask).
- hit_pulse  out  NUM_TARGETS  registered one-hot, one cycle per accepted hit.
- hit_valid  out  1  registered; equals OR of hit_pulse.
- hit_index  out  max(1,$clog2(NUM_TARGETS))  registered binary index of hit; holds its last value when hit_valid=0.
- hits_this_frame  out  $clog2(MAX_HITS_PER_FRAME+1)  accepted hits since the last startOfFrame.
- frame_locked  out  1  1 when hits_this_frame == MAX_HITS_PER_FRAME.
- cooldown_active  out  NUM_TARGETS  1 where the target's cooldown counter is nonzero.
- total_hits  out  16  see Optional Feature.

Behaviour:
- Reset (resetN=1 at posedge): hit_pulse=0, hit_valid=0, hit_index=0, hits_this_frame=0, frame_locked=0, all cooldown counters=0, hit_this_frame mask=0, state=ARMED, total_hits=0. Reset mid-frame discards all pending and accumulated state.
- Eligibility per cycle, for target i: drawing_request_Player & drawing_request_Targets[i] & target_mask[i] & (cd[i]==0) & !hit_this_frame[i].
- Acceptance condition: enable=1, state=ARMED, at least one target eligible.
- On acceptance, the lowest eligible index wins; only one hit is accepted per cycle.
- Latency: hit_pulse, hit_valid and hit_index go high on the clock edge after the sampled overlap cycle and stay high exactly 1 cycle.
- On accepting index k:
  - set hit_this_frame[k].
  - load cd[k] with COOLDOWN_FRAMES.
  - increment hits_this_frame.
  - if the new count equals MAX_HITS_PER_FRAME, state becomes LOCKED and frame_locked=1.
- State machine, two states:
  - ARMED -> LOCKED on the accepting hit that reaches MAX_HITS_PER_FRAME.
  - LOCKED -> ARMED on startOfFrame.
  - ARMED stays ARMED on startOfFrame.
- startOfFrame effects:
  - clear hits_this_frame and hit_this_frame.
  - decrement each nonzero cd[i] by 1; cd saturates at 0, never wraps.
- startOfFrame coinciding with overlap: frame clear is applied first, then the overlap is evaluated as the first event of the new frame.
  - Cooldown eligibility uses cd after the decrement: a target with cd=1 is eligible on the startOfFrame cycle.
  - If accepted, hits_this_frame becomes 1.
- A target hit on the startOfFrame cycle with COOLDOWN_FRAMES=0 is still blocked for the rest of that frame by hit_this_frame.
- enable=0: no acceptance, no pulses; startOfFrame processing continues. any_collision ignores enable.
- Masked targets (target_mask=0) never hit and do not affect priority. Their cd counters still decrement.

Optional Feature:
- Macro COLLISION_ARBITER_STATS_EN.
- Defined: total_hits is a 16-bit counter incremented on every accepted hit. It saturates at 16'hFFFF, is cleared only by reset, and is registered in the same cycle as hit_valid.
- Undefined: total_hits is tied to 16'h0000 and no counter logic is synthesised.

Test Plan:
- Reset, then player+target[3] overlap for 5 cycles (mask all 1, MAX=1) -> one hit_pulse=8'h08, hit_index=3 one cycle after the first overlap cycle; frame_locked=1; no further pulses until startOfFrame.
- MAX=2: targets 2 and 5 overlap the player together for 3 cycles -> pulse index 2 at cycle+1, index 5 at cycle+2, hits_this_frame=2, frame_locked=1.
- COOLDOWN_FRAMES=2: hit target 0 in frame N, keep overlapping -> no hit in frames N and N+1; hit accepted in frame N+2 on the startOfFrame cycle.
- startOfFrame coincident with overlap on target 1 while LOCKED -> unlock; hit accepted (index 1) with hits_this_frame=1 on the next cycle.
- target_mask[4]=0 with overlap on 4 and 6 -> hit_index=6; any_collision=1 only from target 6. enable=0 with the same stimulus -> no pulses, any_collision still 1.
- With COLLISION_ARBITER_STATS_EN: 3 hits across frames -> total_hits=3; assert resetN mid-frame -> all outputs 0 on the next edge, total_hits=0.
